// File: rtl/mux2x1_arb_pkg.sv
// Shared types and helpers for the two-requester mux arbiter.
package mux2x1_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) begin
      res++;
    end
    return res;
  endfunction

endpackage

// File: rtl/mux2x1_w.sv
// Parameterised combinational 2:1 mux.
module mux2x1_w #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = s ? a1 : a0;

endmodule

// File: rtl/mux2x1_arbiter.sv
// Round-robin arbiter sharing one 2:1 mux between two requesters, registered output.
// Define MUX2X1_ARB_STATS_EN to add per-requester grant-cycle counters cnt0/cnt1.
module mux2x1_arbiter
  import mux2x1_arb_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MAXBURST = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             s,
  output logic [WIDTH-1:0] y,
  output logic             yv
`ifdef MUX2X1_ARB_STATS_EN
  ,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
`endif
);

  // MAXBURST=1 would give a zero-width counter; keep at least one bit.
  localparam int unsigned CntW = (clog2(MAXBURST) < 1) ? 1 : clog2(MAXBURST);
  localparam logic [CntW-1:0] CntMax = CntW'(MAXBURST - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            last_q, last_d;
  logic            s_q, s_d;
  logic [WIDTH-1:0] y_q, mux_y;
  logic            yv_q;
  logic            cnt_at_max;

  assign cnt_at_max = (cnt_q == CntMax);

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      s_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      s_q     <= s_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    s_d     = s_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req0 && req1)  state_d = last_q ? ST_G0 : ST_G1;
        else if (req0)     state_d = ST_G0;
        else if (req1)     state_d = ST_G1;
      end
      ST_G0: begin
        if (!req0)                    state_d = req1 ? ST_G1 : ST_IDLE;
        else if (req1 && cnt_at_max)  state_d = ST_G1;
        else if (!cnt_at_max)         cnt_d = cnt_q + CntW'(1);
      end
      ST_G1: begin
        if (!req1)                    state_d = req0 ? ST_G0 : ST_IDLE;
        else if (req0 && cnt_at_max)  state_d = ST_G0;
        else if (!cnt_at_max)         cnt_d = cnt_q + CntW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
    // Select and round-robin pointer follow the granted side; both hold through IDLE.
    if (state_d == ST_G0) begin
      last_d = 1'b0;
      s_d    = 1'b0;
    end else if (state_d == ST_G1) begin
      last_d = 1'b1;
      s_d    = 1'b1;
    end
  end

  always_comb begin
    gnt0 = (state_q == ST_G0);
    gnt1 = (state_q == ST_G1);
    s    = s_q;
    y    = y_q;
    yv   = yv_q;
  end

  mux2x1_w #(
    .WIDTH(WIDTH)
  ) u_mux (
    .a0(a0),
    .a1(a1),
    .s (s_q),
    .y (mux_y)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      y_q  <= '0;
      yv_q <= 1'b0;
    end else if (state_q != ST_IDLE) begin
      y_q  <= mux_y;
      yv_q <= 1'b1;
    end else begin
      yv_q <= 1'b0;
    end
  end

`ifdef MUX2X1_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (state_q == ST_G0) cnt0_q <= cnt0_q + 16'd1;
      if (state_q == ST_G1) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_mux2x1_arbiter.sv
// Directed self-checking bench for mux2x1_arbiter (WIDTH=32, MAXBURST=4).
module tb_mux2x1_arbiter;

  logic        clk;
  logic        clr;
  logic        req0, req1;
  logic [31:0] a0, a1;
  logic        gnt0, gnt1, s, yv;
  logic [31:0] y;
`ifdef MUX2X1_ARB_STATS_EN
  logic [15:0] cnt0, cnt1;
`endif

  int total;
  int bad;

  mux2x1_arbiter #(
    .WIDTH   (32),
    .MAXBURST(4)
  ) dut (
    .clk (clk),
    .clr (clr),
    .req0(req0),
    .req1(req1),
    .a0  (a0),
    .a1  (a1),
    .gnt0(gnt0),
    .gnt1(gnt1),
    .s   (s),
    .y   (y),
    .yv  (yv)
`ifdef MUX2X1_ARB_STATS_EN
    ,
    .cnt0(cnt0),
    .cnt1(cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ctl(input string tag, input logic g0, input logic g1, input logic sel,
                           input logic v);
    check({tag, ".gnt0"}, 32'(gnt0), 32'(g0));
    check({tag, ".gnt1"}, 32'(gnt1), 32'(g1));
    check({tag, ".s"},    32'(s),    32'(sel));
    check({tag, ".yv"},   32'(yv),   32'(v));
  endtask

  initial begin
    logic        exp_g1;
    logic        prev_g1;
    total = 0;
    bad   = 0;
    clr   = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    a0    = '0;
    a1    = '0;

    // 1: reset and idle
    step();
    step();
    check_ctl("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst.y", y, 32'h0);
    clr = 1'b0;
    step();
    check_ctl("idle", 1'b0, 1'b0, 1'b0, 1'b0);
    check("idle.y", y, 32'h0);

    // 2: single requester
    a0   = 32'h11;
    req0 = 1'b1;
    step();
    check_ctl("r0.grant", 1'b1, 1'b0, 1'b0, 1'b0);
    check("r0.grant.y", y, 32'h0);
    step();
    check_ctl("r0.data", 1'b1, 1'b0, 1'b0, 1'b1);
    check("r0.data.y", y, 32'h11);
    req0 = 1'b0;
    a0   = 32'h22;
    step();
    check_ctl("r0.rel", 1'b0, 1'b0, 1'b0, 1'b1);
    check("r0.rel.y", y, 32'h22);
    step();
    check_ctl("r0.idle", 1'b0, 1'b0, 1'b0, 1'b0);
    check("r0.idle.y", y, 32'h22);

    // 3: both requesting from reset, bursts of 4 alternate
    clr = 1'b1;
    step();
    clr  = 1'b0;
    req0 = 1'b1;
    req1 = 1'b1;
    a0   = 32'haaaa_0000;
    a1   = 32'hbbbb_0001;
    prev_g1 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      exp_g1 = (((k - 1) / 4) % 2) == 1;
      check($sformatf("rr%0d", k), {29'b0, gnt0, gnt1, s}, {29'b0, !exp_g1, exp_g1, exp_g1});
      if (k == 1) begin
        check("rr1.yv", 32'(yv), 32'h0);
      end else begin
        check($sformatf("rr%0d.yv", k), 32'(yv), 32'h1);
        check($sformatf("rr%0d.y", k), y, prev_g1 ? 32'hbbbb_0001 : 32'haaaa_0000);
      end
      prev_g1 = exp_g1;
    end
`ifdef MUX2X1_ARB_STATS_EN
    check("stats.cnt0", 32'(cnt0), 32'd8);
    check("stats.cnt1", 32'(cnt1), 32'd7);
`endif

    // 4: release by 0 and request by 1 on the same edge
    clr  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    clr  = 1'b0;
    req0 = 1'b1;
    a0   = 32'h0000_00a0;
    a1   = 32'h0000_00a1;
    step();
    step();
    check_ctl("ho.g0", 1'b1, 1'b0, 1'b0, 1'b1);
    req0 = 1'b0;
    req1 = 1'b1;
    step();
    check_ctl("ho.g1", 1'b0, 1'b1, 1'b1, 1'b1);
    check("ho.g1.y", y, 32'h0000_00a0);
    req0 = 1'b1;
    step();
    check_ctl("ho.data", 1'b0, 1'b1, 1'b1, 1'b1);
    check("ho.data.y", y, 32'h0000_00a1);

    // 5: clr mid G1 burst (cnt=2), then tie goes to requester 0
    step();
    check_ctl("g1.cnt2", 1'b0, 1'b1, 1'b1, 1'b1);
    clr = 1'b1;
    step();
    check_ctl("clr.mid", 1'b0, 1'b0, 1'b0, 1'b0);
    check("clr.mid.y", y, 32'h0);
`ifdef MUX2X1_ARB_STATS_EN
    check("clr.cnt0", 32'(cnt0), 32'd0);
    check("clr.cnt1", 32'(cnt1), 32'd0);
`endif
    clr = 1'b0;
    step();
    check_ctl("post.clr", 1'b1, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
